// File: rtl/fp_lut_precompute_if.sv
// Tile-in / table-out handshake bundle for the FP LUT precompute block.
// Tiles go in on the in_valid/in_ready pair; the table comes out on lut_valid/lut_ready.
interface fp_lut_precompute_if #(
  parameter int A_LUT_BIT = 16,
  parameter int M_DIM     = 2,
  parameter int K_DIM     = 4,
  parameter int A_LUT_DIM = 2**(K_DIM-1)
);
  logic                                         in_valid;
  logic                                         in_ready;
  logic [M_DIM-1:0][K_DIM-1:0][A_LUT_BIT-1:0]     a_in;
  logic                                         lut_valid;
  logic                                         lut_ready;
  logic [M_DIM-1:0][A_LUT_DIM-1:0][A_LUT_BIT-1:0] a_lut;
  logic                                         busy;

  modport master (output in_valid, a_in, lut_ready,
                  input  in_ready, lut_valid, a_lut, busy);
  modport slave  (input  in_valid, a_in, lut_ready,
                  output in_ready, lut_valid, a_lut, busy);
endinterface

// File: rtl/fp_lut_precompute.sv
// Builds per-row 2^(K-1)-entry signed-sum FP tables from one activation tile,
// one adder per row, walking the table in Gray-code order.

// Combinational FP add, round-to-nearest-even. Denormal results flush to zero.
// In non-IEEE mode, denormal inputs are also treated as zero.
module fp_lut_add #(
  parameter int SIG_WIDTH       = 10,
  parameter int EXP_WIDTH       = 5,
  parameter int IEEE_COMPLIANCE = 0
) (
  input  logic [SIG_WIDTH+EXP_WIDTH:0] a,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] b,
  output logic [SIG_WIDTH+EXP_WIDTH:0] z
);
  localparam int W  = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int MW = SIG_WIDTH + 4;  // hidden + fraction + guard/round/sticky
  localparam int EW = EXP_WIDTH + 2;
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_WIDTH) - 1);

  logic [EXP_WIDTH-1:0] xa, xb, be, se, d;
  logic [SIG_WIDTH:0]   ma, mb, bm, sm;
  logic [MW-1:0]        sm_x, al, nrm;
  logic [MW:0]          s;
  logic [EW-1:0]        e;
  logic [SIG_WIDTH:0]   mr;
  logic                 bs, eff_sub, stk, rnd_up;
  int                   lz;

  always_comb begin
    xa = a[W-2:SIG_WIDTH];
    xb = b[W-2:SIG_WIDTH];
    ma = {1'b1, a[SIG_WIDTH-1:0]};
    mb = {1'b1, b[SIG_WIDTH-1:0]};
    if (xa == '0) begin
      ma = (IEEE_COMPLIANCE != 0) ? {1'b0, a[SIG_WIDTH-1:0]} : '0;
      xa = EXP_WIDTH'(1);
    end
    if (xb == '0) begin
      mb = (IEEE_COMPLIANCE != 0) ? {1'b0, b[SIG_WIDTH-1:0]} : '0;
      xb = EXP_WIDTH'(1);
    end
    if ({xb, mb} > {xa, ma}) begin
      be = xb; bm = mb; bs = b[W-1]; se = xa; sm = ma;
    end else begin
      be = xa; bm = ma; bs = a[W-1]; se = xb; sm = mb;
    end
    eff_sub = a[W-1] ^ b[W-1];
    d    = be - se;
    sm_x = {sm, 3'b000};
    stk  = 1'b0;
    al   = '0;
    if (int'(d) >= MW) begin
      stk = |sm;
    end else begin
      al = sm_x >> d;
      for (int j = 0; j < MW; j++)
        if (j < int'(d) && sm_x[j]) stk = 1'b1;
    end
    al[0] = al[0] | stk;
    s = eff_sub ? ({1'b0, bm, 3'b000} - {1'b0, al}) : ({1'b0, bm, 3'b000} + {1'b0, al});

    lz = 0;
    for (int j = 0; j < MW; j++)
      if (s[j]) lz = MW - 1 - j;
    if (s[MW]) begin
      nrm    = s[MW:1];
      nrm[0] = nrm[0] | s[0];
      e      = EW'(be) + EW'(1);
    end else begin
      nrm = s[MW-1:0] << lz;
      e   = EW'(be) - EW'(lz);
    end

    rnd_up = nrm[2] & ((|nrm[1:0]) | nrm[3]);
    mr     = {1'b0, nrm[MW-2:3]} + (SIG_WIDTH+1)'(rnd_up);
    // A fraction carry-out means the mantissa rounded up to exactly 2.0.
    if (mr[SIG_WIDTH]) e = e + EW'(1);

    z = {bs, e[EXP_WIDTH-1:0], mr[SIG_WIDTH-1:0]};
    if (!nrm[MW-1] || e[EW-1] || e == '0) z = '0;
    else if (e >= EMAX) z = {bs, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
  end
endmodule

module fp_lut_precompute #(
  parameter int SIG_WIDTH       = 10,
  parameter int EXP_WIDTH       = 5,
  parameter int IEEE_COMPLIANCE = 0,
  parameter int A_LUT_BIT       = SIG_WIDTH + EXP_WIDTH + 1,
  parameter int M_DIM           = 2,
  parameter int K_DIM           = 4,
  parameter int A_LUT_DIM       = 2**(K_DIM-1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_lut_precompute_if.slave    bus
);
  localparam int CW = K_DIM - 1;
  localparam int KW = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam logic [CW-1:0] LAST_BASE = CW'(K_DIM - 1);
  localparam logic [CW-1:0] LAST_GRAY = CW'(A_LUT_DIM - 1);

  typedef logic [A_LUT_BIT-1:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_BASE, S_GRAY, S_DONE} state_e;

  function automatic word_t fp_neg(word_t x);
    fp_neg = {~x[A_LUT_BIT-1], x[A_LUT_BIT-2:0]};
  endfunction

  // Zero/denormal passes through unchanged so doubling never fabricates a value.
  function automatic word_t fp_dbl(word_t x);
    fp_dbl = x;
    if (x[A_LUT_BIT-2:SIG_WIDTH] != '0)
      fp_dbl[A_LUT_BIT-2:SIG_WIDTH] = x[A_LUT_BIT-2:SIG_WIDTH] + 1'b1;
  endfunction

  state_e state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic [M_DIM-1:0][K_DIM-1:0][A_LUT_BIT-1:0]     a_reg_q, a_reg_d;
  logic [M_DIM-1:0][A_LUT_BIT-1:0]                acc_q, acc_d, addend, sum;
  logic [M_DIM-1:0][A_LUT_DIM-1:0][A_LUT_BIT-1:0] work_q, work_d, a_lut_q, a_lut_d;

  logic [CW-1:0] gcode;
  logic [KW-1:0] sel_idx, base_idx;
  logic          gbit;
  int            p;

  // Entry gray(g) differs from gray(g-1) at the lowest set bit of g.
  always_comb begin
    gcode = step_q ^ (step_q >> 1);
    p = 0;
    for (int j = CW - 1; j >= 0; j--)
      if (step_q[j]) p = j;
    gbit     = gcode[p];
    sel_idx  = KW'(p + 1);
    base_idx = KW'(step_q);
  end

  always_comb begin
    word_t dw;
    for (int i = 0; i < M_DIM; i++) begin
      dw = fp_dbl(a_reg_q[i][sel_idx]);
      if (state_q == S_BASE) addend[i] = fp_neg(a_reg_q[i][base_idx]);
      else                   addend[i] = gbit ? dw : fp_neg(dw);
    end
  end

  for (genvar gi = 0; gi < M_DIM; gi++) begin : g_row
    fp_lut_add #(
      .SIG_WIDTH       (SIG_WIDTH),
      .EXP_WIDTH       (EXP_WIDTH),
      .IEEE_COMPLIANCE (IEEE_COMPLIANCE)
    ) u_add (
      .a (acc_q[gi]),
      .b (addend[gi]),
      .z (sum[gi])
    );
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_reg_d = a_reg_q;
    acc_d   = acc_q;
    work_d  = work_q;
    a_lut_d = a_lut_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) begin
        a_reg_d = bus.a_in;
        for (int i = 0; i < M_DIM; i++) acc_d[i] = bus.a_in[i][0];
        step_d  = CW'(1);
        state_d = S_BASE;
      end
      S_BASE: begin
        acc_d = sum;
        if (step_q == LAST_BASE) begin
          for (int i = 0; i < M_DIM; i++) work_d[i][0] = sum[i];
          step_d  = CW'(1);
          state_d = S_GRAY;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      S_GRAY: begin
        acc_d = sum;
        for (int i = 0; i < M_DIM; i++) work_d[i][gcode] = sum[i];
        if (step_q == LAST_GRAY) begin
          a_lut_d = work_d;
          step_d  = '0;
          state_d = S_DONE;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      S_DONE: if (bus.lut_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      a_reg_q <= '0;
      acc_q   <= '0;
      work_q  <= '0;
      a_lut_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_reg_q <= a_reg_d;
      acc_q   <= acc_d;
      work_q  <= work_d;
      a_lut_q <= a_lut_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.lut_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_BASE) || (state_q == S_GRAY);
  assign bus.a_lut     = a_lut_q;
endmodule

// File: tb/tb_fp_lut_precompute.sv
// Directed bench for fp_lut_precompute; expected tables come from a real-valued
// model, queued at the accept edge and popped when lut_valid is observed.
module tb_fp_lut_precompute;
  localparam int W = 16, M = 2, K = 4, AD = 8;
  typedef logic [M-1:0][K-1:0][W-1:0]  tile_t;
  typedef logic [M-1:0][AD-1:0][W-1:0] tbl_t;

  logic clk, rst_n;
  int checks = 0, errors = 0, cyc = 0, lat;
  tbl_t exp_q[$];
  int acc_cyc[$], rel_cyc[$];
  tile_t t_nom, t_b, t_c, t_z;
  tbl_t e;

  fp_lut_precompute_if #(.A_LUT_BIT(W), .M_DIM(M), .K_DIM(K)) bus ();

  fp_lut_precompute #(.SIG_WIDTH(10), .EXP_WIDTH(5), .IEEE_COMPLIANCE(0),
                      .M_DIM(M), .K_DIM(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic real h2r(logic [15:0] h);
    real m;
    int  ex;
    if (h[14:10] == 5'd0) return 0.0;
    m  = 1.0 + $itor(h[9:0]) / 1024.0;
    ex = int'(h[14:10]) - 15;
    while (ex > 0) begin m = m * 2.0; ex--; end
    while (ex < 0) begin m = m / 2.0; ex++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(real r);
    real  m;
    int   ex, f;
    logic s;
    if (r == 0.0) return 16'h0000;
    s  = (r < 0.0);
    m  = s ? -r : r;
    ex = 15;
    while (m >= 2.0) begin m = m / 2.0; ex++; end
    while (m < 1.0)  begin m = m * 2.0; ex--; end
    f = $rtoi((m - 1.0) * 1024.0 + 0.5);
    return {s, ex[4:0], f[9:0]};
  endfunction

  function automatic tile_t mk(real a0, real a1, real a2, real a3,
                               real b0, real b1, real b2, real b3);
    tile_t t;
    t[0][0] = r2h(a0); t[0][1] = r2h(a1); t[0][2] = r2h(a2); t[0][3] = r2h(a3);
    t[1][0] = r2h(b0); t[1][1] = r2h(b1); t[1][2] = r2h(b2); t[1][3] = r2h(b3);
    return t;
  endfunction

  function automatic tbl_t model(tile_t a);
    tbl_t t;
    real  v;
    for (int i = 0; i < M; i++)
      for (int idx = 0; idx < AD; idx++) begin
        v = h2r(a[i][0]);
        for (int k = 1; k < K; k++)
          v = idx[k-1] ? v + h2r(a[i][k]) : v - h2r(a[i][k]);
        t[i][idx] = r2h(v);
      end
    return t;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.a_in));
      acc_cyc.push_back(cyc);
    end
    if (rst_n && bus.lut_valid && bus.lut_ready) rel_cyc.push_back(cyc);
  end

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic accept(tile_t t);
    bus.a_in     = t;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_lut(output int n);
    n = 0;
    while (!bus.lut_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("lut_valid_seen", bus.lut_valid, 1);
  endtask

  task automatic check_table(string tag, output tbl_t ex);
    chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
    ex = '0;
    if (exp_q.size() > 0) ex = exp_q.pop_front();
    chk(tag, bus.a_lut, ex);
  endtask

  task automatic release_lut();
    bus.lut_ready = 1'b1;
    @(negedge clk);
    bus.lut_ready = 1'b0;
    chk("rel_lut_valid", bus.lut_valid, 0);
    chk("rel_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.lut_ready = 1'b0; bus.a_in = '0;
    t_nom = mk(1.0, 0.5, 0.25, 2.0,   0.5, 1.0, 2.0, 0.125);
    t_b   = mk(3.0, 1.0, 0.5, 0.25,  -2.0, 0.75, 1.5, 0.125);
    t_c   = mk(-1.0, 0.25, 4.0, 1.5,  6.0, 0.375, 0.5, 1.0);
    t_z   = mk(0.0, 0.0, 1.0, 0.0,    1.0, 0.5, 0.25, 2.0);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_lut_valid", bus.lut_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_a_lut", bus.a_lut, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal tile and latency
    accept(t_nom);
    chk("nom_busy", bus.busy, 1);
    chk("nom_in_ready", bus.in_ready, 0);
    wait_lut(lat);
    chk("nom_latency", lat, 10);
    check_table("nom_table", e);
    chk("nom_lut00", bus.a_lut[0][0], 16'hBF00);
    chk("nom_lut01", bus.a_lut[0][1], 16'hBA00);
    chk("nom_lut07", bus.a_lut[0][7], 16'h4380);
    release_lut();

    // Backpressure: table held, new tiles ignored
    accept(t_b);
    wait_lut(lat);
    check_table("bp_table", e);
    repeat (20) begin
      bus.in_valid = 1'b1;
      bus.a_in     = t_c;
      @(negedge clk);
      chk("bp_lut_valid", bus.lut_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_a_lut", bus.a_lut, e);
    end
    bus.in_valid = 1'b0;
    chk("bp_no_accept", exp_q.size(), 0);
    release_lut();

    // Zero operands: doubling must leave zeros alone
    accept(t_z);
    wait_lut(lat);
    check_table("zero_table", e);
    for (int idx = 0; idx < AD; idx++)
      chk($sformatf("zero_lut0_%0d", idx), bus.a_lut[0][idx],
          idx[1] ? 16'h3C00 : 16'hBC00);
    release_lut();

    // Back-to-back with in_valid held and lut_ready tied high
    acc_cyc.delete();
    rel_cyc.delete();
    bus.a_in = t_b; bus.in_valid = 1'b1; bus.lut_ready = 1'b1;
    @(negedge clk);
    bus.a_in = t_c;
    wait_lut(lat);
    chk("b2b_latency1", lat, 10);
    check_table("b2b_first", e);
    @(negedge clk);
    chk("b2b_idle_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_lut(lat);
    chk("b2b_latency2", lat, 10);
    check_table("b2b_second", e);
    @(negedge clk);
    bus.lut_ready = 1'b0;
    chk("b2b_gap", acc_cyc[1] - rel_cyc[0], 1);
    chk("b2b_period", acc_cyc[1] - acc_cyc[0], 12);

    // Reset in the middle of GRAY discards the tile
    accept(t_b);
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_lut_valid", bus.lut_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_a_lut", bus.a_lut, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh tile after reset; a_in changes right after accept
    accept(t_nom);
    bus.a_in = t_z;
    wait_lut(lat);
    chk("post_rst_latency", lat, 10);
    check_table("post_rst_table", e);
    release_lut();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
